// File: rtl/int_pc_sequencer_pkg.sv
// Shared constants and types for the three-source interrupt PC sequencer.
// Covers the vector layout, handler level encoding and return-stack entry format.
package int_pc_sequencer_pkg;

  localparam logic [31:0] VEC_BASE    = 32'h0000_0800;
  localparam logic [31:0] VEC_STRIDE  = 32'h0000_0100;
  localparam int          NUM_SRC     = 3;
  localparam int          STACK_DEPTH = 3;

  // Level n (1..3) means a handler for source n-1 is running.
  typedef enum logic [1:0] {
    LVL_NONE = 2'd0,
    LVL_SRC0 = 2'd1,
    LVL_SRC1 = 2'd2,
    LVL_SRC2 = 2'd3
  } lvl_e;

  typedef struct packed {
    lvl_e        lvl;
    logic [31:0] epc;
  } epc_entry_t;

  function automatic logic [31:0] vector_addr(input logic [31:0] base,
                                              input logic [31:0] stride,
                                              input logic [1:0]  src);
    return base + stride * {30'd0, src};
  endfunction

  function automatic lvl_e src_to_lvl(input logic [1:0] src);
    return lvl_e'(src + 2'd1);
  endfunction

endpackage

// File: rtl/int_pc_sequencer_if.sv
// Bus between the core's PC update logic and the interrupt PC sequencer.
// The master side is the core, the slave side is the sequencer.
interface int_pc_sequencer_if;

  logic [31:0] PC_Next;
  logic        InstrValid;
  logic        ERET;
  logic        IE;
  logic [2:0]  IntMask;
  logic [2:0]  IRQ;
  logic [31:0] PC_Out;
  logic [2:0]  IntAck;
  logic        IntActive;
  logic [1:0]  CurLvl;
  logic [2:0]  Pending;
  logic [31:0] EPC_Top;

  modport master (
    output PC_Next, InstrValid, ERET, IE, IntMask, IRQ,
    input  PC_Out, IntAck, IntActive, CurLvl, Pending, EPC_Top
  );

  modport slave (
    input  PC_Next, InstrValid, ERET, IE, IntMask, IRQ,
    output PC_Out, IntAck, IntActive, CurLvl, Pending, EPC_Top
  );

endinterface

// File: rtl/int_pc_sequencer_epc_stack.sv
// Three-entry LIFO of {saved level, return PC} for nested interrupt handlers.
// top reads as all-zero while the stack is empty.
module int_pc_sequencer_epc_stack
  import int_pc_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       en,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  epc_entry_t din,
  output epc_entry_t top,
  output logic       empty
);

  epc_entry_t entry_q [STACK_DEPTH];
  epc_entry_t entry_d [STACK_DEPTH];
  logic [1:0] sp_q, sp_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    entry_d = entry_q;
    sp_d    = sp_q;
    if (push && (sp_q != 2'(STACK_DEPTH))) begin
      entry_d[sp_q] = din;
      sp_d          = sp_q + 2'd1;
    end else if (pop && (sp_q != 2'd0)) begin
      sp_d = sp_q - 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (en) begin
      if (rst) begin
        sp_q <= 2'd0;
        // NOTE: the entries are cleared too, so EPC state is never X after reset.
        for (int i = 0; i < STACK_DEPTH; i++) entry_q[i] <= '0;
      end else begin
        sp_q    <= sp_d;
        entry_q <= entry_d;
      end
    end
  end

  assign empty = (sp_q == 2'd0);

  always_comb begin
    top = '0;
    if (!empty) top = entry_q[sp_q - 2'd1];
  end

endmodule

// File: rtl/int_pc_sequencer.sv
// Prioritised three-source interrupt sequencer between PC update logic and the PC register.
// Redirects to vectors, returns via ERET, and nests handlers by strict priority.
module int_pc_sequencer
  import int_pc_sequencer_pkg::*;
#(
  parameter logic [31:0] VecBase   = VEC_BASE,
  parameter logic [31:0] VecStride = VEC_STRIDE
) (
  input  logic [4:0]         LOGISIM_CLOCK_TREE_0,
  input  logic               Reset,
  int_pc_sequencer_if.slave  bus
);

  logic clk;
  logic tick;
  logic unused_tree;

  assign clk         = LOGISIM_CLOCK_TREE_0[4];
  assign tick        = LOGISIM_CLOCK_TREE_0[2];
  assign unused_tree = ^{LOGISIM_CLOCK_TREE_0[3], LOGISIM_CLOCK_TREE_0[1:0]};

  logic [2:0] irq_prev_q, irq_prev_d;
  logic [2:0] pending_q, pending_d;
  lvl_e       cur_lvl_q, cur_lvl_d;

  logic [2:0] rise;
  logic [2:0] elig;
  logic [2:0] ack;
  logic [1:0] winner;
  logic       take;
  logic       ret;
  logic [31:0] pc_out;

  epc_entry_t stack_top;
  epc_entry_t push_data;
  logic       stack_empty;

  // A source is eligible only if it outranks the handler currently running.
  always_comb begin
    rise   = bus.IRQ & ~irq_prev_q;
    elig   = '0;
    winner = 2'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      elig[i] = pending_q[i] & bus.IntMask[i] & bus.IE & ((i + 1) > int'(cur_lvl_q));
      if (elig[i]) winner = 2'(i);
    end
  end

  assign take = bus.InstrValid & ~bus.ERET & (elig != 3'b000);
  assign ret  = bus.InstrValid & bus.ERET & (cur_lvl_q != LVL_NONE) & ~stack_empty;
  assign ack  = take ? (3'b001 << winner) : 3'b000;

  always_comb begin
    pc_out = bus.PC_Next;
    if (take)     pc_out = vector_addr(VecBase, VecStride, winner);
    else if (ret) pc_out = stack_top.epc;
  end

  // A new edge on the source being taken re-arms it, so set wins over clear.
  always_comb begin
    irq_prev_d = bus.IRQ;
    pending_d  = (pending_q & ~ack) | rise;
    cur_lvl_d  = cur_lvl_q;
    if (take)     cur_lvl_d = src_to_lvl(winner);
    else if (ret) cur_lvl_d = stack_top.lvl;
  end

  assign push_data = '{lvl: cur_lvl_q, epc: bus.PC_Next};

  always_ff @(posedge clk) begin
    if (tick) begin
      if (Reset) begin
        irq_prev_q <= 3'b000;
        pending_q  <= 3'b000;
        cur_lvl_q  <= LVL_NONE;
      end else begin
        irq_prev_q <= irq_prev_d;
        pending_q  <= pending_d;
        cur_lvl_q  <= cur_lvl_d;
      end
    end
  end

  int_pc_sequencer_epc_stack u_stack (
    .clk   (clk),
    .en    (tick),
    .rst   (Reset),
    .push  (take),
    .pop   (ret),
    .din   (push_data),
    .top   (stack_top),
    .empty (stack_empty)
  );

  assign bus.PC_Out    = pc_out;
  assign bus.IntAck    = ack;
  assign bus.IntActive = (cur_lvl_q != LVL_NONE);
  assign bus.CurLvl    = cur_lvl_q;
  assign bus.Pending   = pending_q;
  assign bus.EPC_Top   = stack_top.epc;

endmodule

// File: tb/tb_int_pc_sequencer.sv
// Scoreboard bench for int_pc_sequencer: directed nesting scenarios then random traffic,
// checked against a queue-based behavioural model of the interrupt rules.
module tb_int_pc_sequencer;
  import int_pc_sequencer_pkg::*;

  logic clk_bit = 1'b0;
  logic tick    = 1'b1;
  logic rst     = 1'b0;
  logic [4:0] tree;

  assign tree = {clk_bit, 1'b0, tick, 2'b00};
  always #5 clk_bit = ~clk_bit;

  int_pc_sequencer_if bus();

  int_pc_sequencer dut (
    .LOGISIM_CLOCK_TREE_0 (tree),
    .Reset                (rst),
    .bus                  (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  ack;
    logic [1:0]  lvl;
    logic        active;
    logic [2:0]  pend;
    logic [31:0] epc;
    int          depth;
    int          spot_pc;
    int          spot_lvl;
  } exp_t;

  typedef struct {
    logic [1:0]  lvl;
    logic [31:0] epc;
  } frame_t;

  exp_t   exp_q[$];
  frame_t m_stack[$];
  logic [2:0] m_pend = 3'b000;
  logic [2:0] m_prev = 3'b000;
  int         m_lvl  = 0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Drives one cycle and advances the model; arguments are
  // (pc, valid, eret, ie, mask, irq, tick, reset, record, spot_pc, spot_lvl).
  task automatic step(input logic [31:0] pc, input bit valid, input bit eret, input bit ie,
                      input logic [2:0] mask, input logic [2:0] irq, input bit tk, input bit rs,
                      input bit rec, input int spot_pc = -1, input int spot_lvl = -1);
    int   win;
    bit   take;
    bit   ret;
    exp_t e;
    @(negedge clk_bit);
    bus.PC_Next    = pc;
    bus.InstrValid = valid;
    bus.ERET       = eret;
    bus.IE         = ie;
    bus.IntMask    = mask;
    bus.IRQ        = irq;
    tick           = tk;
    rst            = rs;

    win = -1;
    for (int i = 0; i < 3; i++)
      if (m_pend[i] && mask[i] && ie && (i + 1 > m_lvl)) win = i;
    take = valid && !eret && (win >= 0);
    ret  = valid && eret && (m_lvl != 0);

    e.pc       = take ? VEC_BASE + VEC_STRIDE * 32'(win) : (ret ? m_stack[$].epc : pc);
    e.ack      = take ? 3'(1 << win) : 3'b000;
    e.lvl      = 2'(m_lvl);
    e.active   = (m_lvl != 0);
    e.pend     = m_pend;
    e.epc      = (m_stack.size() != 0) ? m_stack[$].epc : 32'h0;
    e.depth    = m_stack.size();
    e.spot_pc  = spot_pc;
    e.spot_lvl = spot_lvl;
    if (rec) exp_q.push_back(e);

    if (tk) begin
      if (rs) begin
        m_pend = 3'b000;
        m_prev = 3'b000;
        m_lvl  = 0;
        m_stack.delete();
      end else begin
        if (take) begin
          m_stack.push_back('{lvl: 2'(m_lvl), epc: pc});
          m_pend[win] = 1'b0;
          m_lvl       = win + 1;
        end else if (ret) begin
          m_lvl = int'(m_stack[$].lvl);
          void'(m_stack.pop_back());
        end
        m_pend = m_pend | (irq & ~m_prev);
        m_prev = irq;
      end
    end
    assert (m_stack.size() <= 3);
  endtask

  task automatic dstep(input logic [31:0] pc, input bit valid, input bit eret,
                       input logic [2:0] irq, input bit ie, input int spot_pc, input int spot_lvl);
    step(pc, valid, eret, ie, 3'b111, irq, 1'b1, 1'b0, 1'b1, spot_pc, spot_lvl);
  endtask

  // Monitor: compares each presented cycle against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_bit);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pc_out",     bus.PC_Out,    e.pc);
        check("int_ack",    bus.IntAck,    e.ack);
        check("cur_lvl",    bus.CurLvl,    e.lvl);
        check("int_active", bus.IntActive, e.active);
        check("pending",    bus.Pending,   e.pend);
        check("epc_top",    bus.EPC_Top,   e.epc);
        check("stack_depth", 32'(dut.u_stack.sp_q), 32'(e.depth));
        if (e.spot_pc >= 0)  check("plan_pc",  bus.PC_Out, 32'(e.spot_pc));
        if (e.spot_lvl >= 0) check("plan_lvl", bus.CurLvl, 32'(e.spot_lvl));
      end
    end
  end

  initial begin
    logic [2:0] irq_r;
    logic [2:0] mask_r;
    bus.PC_Next = '0; bus.InstrValid = 1'b0; bus.ERET = 1'b0;
    bus.IE = 1'b0; bus.IntMask = '0; bus.IRQ = '0;

    step(32'h100, 0, 0, 1, 3'b111, 3'b000, 1, 1, 0);

    // Source 0 taken, then source 2 nests, then two returns unwind.
    dstep(32'h100, 0, 0, 3'b000, 1, 'h100, 0);
    dstep(32'h100, 0, 0, 3'b001, 1, 'h100, 0);
    dstep(32'h100, 1, 0, 3'b001, 1, 'h800, 0);
    dstep(32'h804, 0, 0, 3'b100, 1, 'h804, 1);
    dstep(32'h804, 1, 0, 3'b100, 1, 'hA00, 1);
    dstep(32'hA04, 1, 1, 3'b100, 1, 'h804, 3);
    dstep(32'h808, 1, 1, 3'b100, 1, 'h100, 1);
    // Source 1 blocked at level 3, taken once back at level 0.
    dstep(32'h104, 1, 0, 3'b000, 1, 'h104, 0);
    dstep(32'h108, 0, 0, 3'b100, 1, 'h108, 0);
    dstep(32'h108, 1, 0, 3'b100, 1, 'hA00, 0);
    dstep(32'hA04, 1, 0, 3'b110, 1, 'hA04, 3);
    dstep(32'hA08, 1, 0, 3'b110, 1, 'hA08, 3);
    dstep(32'hA0C, 1, 1, 3'b110, 1, 'h108, 3);
    dstep(32'h10C, 1, 0, 3'b110, 1, 'h900, 0);
    // ERET wins over an eligible request; the take follows next cycle.
    dstep(32'h904, 0, 0, 3'b111, 1, 'h904, 2);
    dstep(32'h908, 1, 1, 3'b111, 1, 'h10C, 2);
    dstep(32'h110, 1, 0, 3'b111, 1, 'h800, 0);
    dstep(32'h804, 1, 1, 3'b111, 1, 'h110, 1);
    // IE=0 holds requests; a fresh edge in the take cycle re-arms the source.
    dstep(32'h114, 1, 0, 3'b000, 0, 'h114, 0);
    dstep(32'h118, 1, 0, 3'b001, 0, 'h118, 0);
    dstep(32'h11C, 1, 0, 3'b000, 0, 'h11C, 0);
    dstep(32'h120, 1, 0, 3'b001, 1, 'h800, 0);
    dstep(32'h804, 1, 1, 3'b001, 0, 'h120, 1);
    dstep(32'h124, 1, 0, 3'b001, 0, 'h124, 0);
    dstep(32'h128, 1, 0, 3'b001, 1, 'h800, 0);
    // Reset from level 2.
    dstep(32'h804, 0, 0, 3'b011, 1, 'h804, 1);
    dstep(32'h804, 1, 0, 3'b011, 1, 'h900, 1);
    step(32'h904, 0, 0, 1, 3'b111, 3'b011, 1, 1, 1, 'h904, 2);
    dstep(32'h200, 1, 0, 3'b011, 1, 'h200, 0);

    // Random traffic including disabled ticks, masking and occasional reset.
    irq_r = 3'b011;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 99) < 20) irq_r[b] = ~irq_r[b];
      mask_r = ($urandom_range(0, 99) < 70) ? 3'b111 : 3'($urandom_range(0, 7));
      step($urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 99) < 80,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 90,
           mask_r, irq_r,
           $urandom_range(0, 99) < 85,
           $urandom_range(0, 199) == 0,
           1'b1);
    end

    repeat (3) @(negedge clk_bit);
    #3;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/int_pc_sequencer.md
Name: int_pc_sequencer

Overview:
Three-source prioritised interrupt sequencer for the single-cycle MIPS core. It sits between the PC update logic and the PC register. Each instruction cycle it either passes the normal next PC through, redirects to an interrupt vector, or returns from a handler.
It saves return addresses on an internal 3-deep stack, which supports nested interrupts by strict priority (source 2 highest).

Parameters:
VecBase, 32'h00000800, handler address for source 0
VecStride, 32'h00000100, address spacing between vectors; vector(i) = VecBase + i*VecStride
(number of sources is fixed at 3 and is not a parameter)

Ports:
LOGISIM_CLOCK_TREE_0  in  5  clock tree; all registers clock on [4] and update only when tick [2]=1 (one "cycle" = one enabled tick)
Reset  in  1  synchronous, active-high
PC_Next  in  32  next PC from the PC update logic (branch/jump already resolved)
InstrValid  in  1  current instruction retires this cycle
ERET  in  1  decoded return-from-interrupt instruction
IE  in  1  global interrupt enable
IntMask  in  3  per-source enable
IRQ  in  3  request lines, rising-edge sensitive
PC_Out  out  32  PC to load into the PC register
IntAck  out  3  one-hot; pulses in the cycle a source is taken
IntActive  out  1  CurLvl != 0
CurLvl  out  2  0 = no handler active; 1..3 = serving source 0..2
Pending  out  3  latched requests
EPC_Top  out  32  top stack entry; 0 when stack is empty

Behaviour:
- Reset (synchronous, on an enabled tick): IRQ_prev=0, Pending=0, CurLvl=0, stack pointer=0, all stack entries=0.
  - Combinational outputs after reset: PC_Out=PC_Next, IntAck=0.
- Edge capture:
  - rise[i] = IRQ[i] & ~IRQ_prev[i]; IRQ_prev <= IRQ every cycle.
  - Pending[i] is set by rise[i] and cleared when source i is taken.
  - If set and clear occur in the same cycle, set wins.
- Eligibility:
  - elig[i] = Pending[i] & IntMask[i] & IE & ((i+1) > CurLvl).
  - Take = InstrValid & ~ERET & (elig != 0).
  - The winner is the highest eligible i.
- Take cycle:
  - combinational: PC_Out = vector(winner); IntAck[winner]=1.
  - at the tick: push {CurLvl, PC_Next} (PC_Next keeps any branch or jump target); CurLvl <= winner+1; Pending[winner] cleared.
- Return cycle (InstrValid & ERET & CurLvl != 0):
  - combinational: PC_Out = top EPC.
  - at the tick: pop; CurLvl <= saved level.
  - Pending requests are not evaluated this cycle. The earliest take is the next valid cycle, so one instruction always executes after a return.
- ERET with CurLvl=0: treated as a normal instruction. PC_Out=PC_Next; no state change.
- InstrValid=0: PC_Out=PC_Next, no take or return. Pending still accumulates edges.
- Changing IE or IntMask mid-handler does not alter CurLvl or the stack. Masked requests stay pending.
- Stack depth: 3 is sufficient because strict priority allows at most 3 nested levels.
  - Overflow is unreachable by construction. The bench asserts pointer ≤ 3.
- Latency: redirect and return are zero-cycle, since PC_Out is combinational in the same cycle. Registered state changes at the next enabled tick.
- No other state machine; state = {CurLvl, stack pointer, stack, Pending, IRQ_prev}.

Decomposition:
- Shared package/header: VecBase, VecStride, level encodings (LVL_NONE=0, LVL_SRC0..2 = 1..3), stack depth constant 3.
- Sub-module epc_stack: 3-entry LIFO of {lvl[1:0], epc[31:0]}.
  - Inputs: push, pop, data in.
  - Outputs: top, empty.
  - Has its own synchronous reset.
- Priority select and PC mux stay in the top level.

Test Plan:
1. Reset, IE=1, mask=7, PC_Next=0x100, IRQ[0] rises -> next valid cycle: PC_Out=0x800, IntAck=001; after the tick CurLvl=1, EPC_Top=0x100.
2. Source 2 rising while CurLvl=1, PC_Next=0x804 -> PC_Out=0xA00, IntAck=100. Then ERET gives PC_Out=0x804, CurLvl=1; a second ERET gives PC_Out=0x100, CurLvl=0.
3. IRQ[1] rises while CurLvl=3 -> no take, Pending=010. After ERET to level 0, the next valid cycle takes it: PC_Out=0x900.
4. ERET and pending eligible IRQ[0] in the same cycle at CurLvl=2 -> PC_Out=EPC, no IntAck. The take happens on the following valid cycle.
5. IRQ[0] rising in its own take cycle -> Pending[0] stays 1. IE=0 holds it pending; raising IE=1 then takes it.
6. Reset asserted mid-handler (CurLvl=2) -> the next cycle shows CurLvl=0, Pending=0, EPC_Top=0, PC_Out=PC_Next.
